hilo_ctrl: RTL and testbench
============================

Name: hilo_ctrl

Overview:
- Sits directly downstream of the multiply and divide units in the 54-instruction CPU.
- Sequences MULT/MULTU/DIV/DIVU: raises the unit's start level, waits on its ready, captures the 64-bit result into the architectural HI/LO registers, and stalls the pipeline meanwhile.
- Also executes MTHI/MTLO and presents HI/LO for MFHI/MFLO.

Parameters:
- TIMEOUT_CYCLES, 64, maximum wait-state cycles before an operation is abandoned (must be >=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- op_valid  in  1  one-cycle strobe: op is a newly issued HI/LO instruction.
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- rs_data  in  32  source value for MTHI/MTLO.
- mul_start  out  1  level request to the multiplier (its instruction-enable input).
- mul_ready  in  1  multiplier result valid.
- mul_z  in  64  multiplier product.
- mul_signed  out  1  1 for MULT, 0 for MULTU; valid while mul_start=1.
- div_start  out  1  level request to the divider.
- div_signed  out  1  1 for DIV, 0 for DIVU; valid while div_start=1.
- div_ready  in  1  divider result valid.
- div_q  in  32  quotient.
- div_r  in  32  remainder.
- hi_out  out  32  architectural HI.
- lo_out  out  32  architectural LO.
- stall  out  1  holds the pipeline (combinational).
- err  out  1  one-cycle pulse when an operation times out.

Behaviour:

Reset:
- reset=0 asynchronously forces state IDLE and wait counter 0.
- hi_out, lo_out, mul_start, div_start, mul_signed, div_signed and err are all 0 during reset.
- stall is 0 during reset.
- Reset mid-operation abandons the operation with no HI/LO update.

States: IDLE, MUL_WAIT, DIV_WAIT.

IDLE:
- op_valid with op 1/2: go to MUL_WAIT next edge.
- op_valid with op 3/4: go to DIV_WAIT next edge.
- op_valid with op 5: hi_out <= rs_data at next edge, stays IDLE, no stall.
- op_valid with op 6: lo_out <= rs_data at next edge, stays IDLE, no stall.
- op 0/7 or op_valid=0: no effect.

MUL_WAIT:
- mul_start=1 for the whole state.
- A mul_ready=1 cycle (the first cycle of the state counts) captures hi<=mul_z[63:32] and lo<=mul_z[31:0] at that edge; return to IDLE.

DIV_WAIT:
- div_start=1 for the whole state.
- On div_ready=1, capture hi<=div_r and lo<=div_q at that edge; return to IDLE.

Stall:
- stall = (state!=IDLE) | (state==IDLE & op_valid & op in 1..4).
- With a zero-latency unit, stall is high for exactly 2 cycles: the issue cycle and one wait cycle.
- hi_out/lo_out show the new value in the first cycle after stall falls.

Timeout:
- The wait counter clears on entry to a WAIT state and increments each wait cycle without ready.
- If the counter equals TIMEOUT_CYCLES-1 and ready=0, the block returns to IDLE at the next edge with HI/LO unchanged.
- err pulses 1 in the cycle after that edge.
- A ready in the final allowed cycle wins over the timeout.

Other rules:
- op_valid while not IDLE is ignored; the pipeline is stalled, so this is a protocol violation.
- No arithmetic is done here; widths are pass-through only.
- Divide-by-zero results are whatever div_q/div_r present, captured unchanged.

Decomposition:
- Package hilo_pkg holds: op encodings (OP_NONE..OP_MTLO), the state enum (IDLE, MUL_WAIT, DIV_WAIT), and the wait-counter width function clog2(TIMEOUT_CYCLES).
- One natural sub-module: hilo_wait_timer, containing the counter, its clear/enable, and the expiry flag.
- The FSM and HI/LO registers stay in hilo_ctrl.

Test Plan:
- Reset released, no ops -> hi_out=0, lo_out=0, stall=0, mul_start=div_start=0 throughout.
- MULTU, mul_ready tied 1, mul_z=0xFFFFFFFE_00000001 -> stall high 2 cycles, mul_start high 1 cycle, mul_signed=0, then HI=0xFFFFFFFE, LO=0x00000001.
- DIVU, div_ready after 33 wait cycles, q=14, r=2 -> div_signed=0, stall high 34 cycles total, then HI=0x00000002, LO=0x0000000E, err=0.
- MTHI rs_data=0xDEADBEEF, then next cycle MTLO rs_data=0x12345678 -> no stall; HI=0xDEADBEEF, then LO=0x12345678, one edge each.
- TIMEOUT_CYCLES=8, DIV with div_ready held 0, HI/LO preloaded 0xA/0xB -> back in IDLE after 8 wait cycles, err pulses exactly once, HI/LO still 0xA/0xB.
- MULT waiting, reset asserted mid-wait, then later mul_ready=1 -> outputs 0 immediately on reset, no capture after release, mul_signed=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO controller: instruction codes, FSM states
// and the wait-counter width helper.
package hilo_pkg;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/hilo_if.sv
// Issue port plus multiplier/divider handshakes and HI/LO results.
interface hilo_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic        mul_start;
    logic        mul_signed;
    logic        mul_ready;
    logic [63:0] mul_z;
    logic        div_start;
    logic        div_signed;
    logic        div_ready;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        stall;
    logic        err;

    modport slave (
        input  op_valid, op, rs_data, mul_ready, mul_z, div_ready, div_q, div_r,
        output mul_start, mul_signed, div_start, div_signed, hi_out, lo_out, stall, err
    );
    modport master (
        output op_valid, op, rs_data, mul_ready, mul_z, div_ready, div_q, div_r,
        input  mul_start, mul_signed, div_start, div_signed, hi_out, lo_out, stall, err
    );
endinterface

// File: rtl/hilo_wait_timer.sv
// Wait-state counter: held at zero while clr, counts each enabled cycle,
// flags the last allowed wait cycle.
module hilo_wait_timer import hilo_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: drives mult/div start levels, captures 64-bit results,
// executes MTHI/MTLO and stalls the pipeline while a unit is busy.
module hilo_ctrl import hilo_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic   clk,
    input  logic   reset,
    hilo_if.slave  bus
);
    state_t      state, state_nx;
    logic [31:0] hi_q, lo_q, hi_nx, lo_nx;
    logic        sgn_q, sgn_nx;
    logic        err_q, err_nx;
    logic        waiting, ready, expired, issue_mul, issue_div;

    assign waiting   = (state != IDLE);
    assign ready     = (state == MUL_WAIT) ? bus.mul_ready : bus.div_ready;
    assign issue_mul = bus.op_valid & ((bus.op == OP_MULT) | (bus.op == OP_MULTU));
    assign issue_div = bus.op_valid & ((bus.op == OP_DIV)  | (bus.op == OP_DIVU));

    hilo_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!waiting),
        .en      (waiting & !ready),
        .expired (expired)
    );

    always_comb begin
        state_nx = state;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        sgn_nx   = sgn_q;
        err_nx   = 1'b0;
        case (state)
            IDLE: if (bus.op_valid) begin
                case (bus.op)
                    OP_MULT, OP_MULTU: begin
                        state_nx = MUL_WAIT;
                        sgn_nx   = (bus.op == OP_MULT);
                    end
                    OP_DIV, OP_DIVU: begin
                        state_nx = DIV_WAIT;
                        sgn_nx   = (bus.op == OP_DIV);
                    end
                    OP_MTHI: hi_nx = bus.rs_data;
                    OP_MTLO: lo_nx = bus.rs_data;
                    default: ;
                endcase
            end
            // ready is checked before expiry so a late result still lands
            MUL_WAIT: begin
                if (bus.mul_ready) begin
                    hi_nx    = bus.mul_z[63:32];
                    lo_nx    = bus.mul_z[31:0];
                    state_nx = IDLE;
                end else if (expired) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            DIV_WAIT: begin
                if (bus.div_ready) begin
                    hi_nx    = bus.div_r;
                    lo_nx    = bus.div_q;
                    state_nx = IDLE;
                end else if (expired) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
            sgn_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            sgn_q <= sgn_nx;
            err_q <= err_nx;
        end
    end

    assign bus.mul_start  = (state == MUL_WAIT);
    assign bus.div_start  = (state == DIV_WAIT);
    assign bus.mul_signed = bus.mul_start & sgn_q;
    assign bus.div_signed = bus.div_start & sgn_q;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
    assign bus.err        = err_q;
    // reset gating keeps stall low even if the issue stage strobes during reset
    assign bus.stall      = reset & (waiting | issue_mul | issue_div);
endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench: two controllers (TIMEOUT 64 and 8), directed vectors,
// a negedge monitor pops expected HI/LO/err on each completion.
module tb_hilo_ctrl;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst, v, mr, dr;
    logic [1:0][2:0]   opv;
    logic [1:0][31:0]  rsd, dq, drem;
    logic [1:0][63:0]  mz;

    hilo_if ia();
    hilo_if ib();

    assign ia.op_valid = v[0];    assign ib.op_valid = v[1];
    assign ia.op       = opv[0];  assign ib.op       = opv[1];
    assign ia.rs_data  = rsd[0];  assign ib.rs_data  = rsd[1];
    assign ia.mul_ready = mr[0];  assign ib.mul_ready = mr[1];
    assign ia.mul_z    = mz[0];   assign ib.mul_z    = mz[1];
    assign ia.div_ready = dr[0];  assign ib.div_ready = dr[1];
    assign ia.div_q    = dq[0];   assign ib.div_q    = dq[1];
    assign ia.div_r    = drem[0]; assign ib.div_r    = drem[1];

    wire [1:0][31:0] hi_w    = {ib.hi_out, ia.hi_out};
    wire [1:0][31:0] lo_w    = {ib.lo_out, ia.lo_out};
    wire [1:0]       stall_w = {ib.stall, ia.stall};
    wire [1:0]       ms_w    = {ib.mul_start, ia.mul_start};
    wire [1:0]       msg_w   = {ib.mul_signed, ia.mul_signed};
    wire [1:0]       ds_w    = {ib.div_start, ia.div_start};
    wire [1:0]       dsg_w   = {ib.div_signed, ia.div_signed};
    wire [1:0]       err_w   = {ib.err, ia.err};

    hilo_ctrl #(.TIMEOUT_CYCLES(64)) dut_a (.clk(clk), .reset(rst[0]), .bus(ia));
    hilo_ctrl #(.TIMEOUT_CYCLES(8))  dut_b (.clk(clk), .reset(rst[1]), .bus(ib));

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic push(input bit w, input logic [31:0] h, input logic [31:0] l, input logic e);
        exp_t x;
        x = '{hi: h, lo: l, err: e};
        if (w) q1.push_back(x);
        else   q0.push_back(x);
    endtask

    // Monitor: a completion is stall falling or HI/LO changing outside reset
    logic [1:0]       pst;
    logic [1:0][31:0] phi, plo;

    task automatic mon(input bit w);
        exp_t e;
        if (!rst[w]) begin
            pst[w] = 1'b0;
        end else if ((pst[w] && !stall_w[w]) || hi_w[w] !== phi[w] || lo_w[w] !== plo[w]) begin
            if ((w ? q1.size() : q0.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update dut%0d: hi %h lo %h err %b, want none", w, hi_w[w], lo_w[w], err_w[w]);
            end else begin
                e = w ? q1.pop_front() : q0.pop_front();
                chk(w ? "result_b" : "result_a", 72'({hi_w[w], lo_w[w], err_w[w]}), 72'(e));
            end
        end
        if (rst[w]) pst[w] = stall_w[w];
        phi[w] = hi_w[w];
        plo[w] = lo_w[w];
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    // Issue one op, run n further cycles; ready pulses in wait cycle rdy_at
    task automatic run(input bit w, input logic [2:0] o, input logic [31:0] rs, input int n,
                       input int rdy_at, output int st, output int ms, output int ds,
                       output int ec, output logic msg, output logic dsg);
        st = 0; ms = 0; ds = 0; ec = 0; msg = 1'b0; dsg = 1'b0;
        @(posedge clk); #1;
        v[w] = 1'b1; opv[w] = o; rsd[w] = rs;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (k == 1) begin v[w] = 1'b0; opv[w] = 3'd0; end
                if (rdy_at > 0) begin mr[w] = (k == rdy_at); dr[w] = (k == rdy_at); end
            end
            @(negedge clk);
            st += int'(stall_w[w]);
            ms += int'(ms_w[w]);
            ds += int'(ds_w[w]);
            ec += int'(err_w[w]);
            if (ms_w[w]) msg |= msg_w[w];
            if (ds_w[w]) dsg |= dsg_w[w];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, ms, ds, ec, acc;
        logic msg, dsg;
        rst = '0; v = '0; mr = '0; dr = '0; opv = '0; rsd = '0; dq = '0; drem = '0; mz = '0;
        pst = '0; phi = '0; plo = '0;

        // op strobe during reset must not raise stall
        repeat (2) @(posedge clk);
        #1 v = 2'b11; opv[0] = 3'd1; opv[1] = 3'd3;
        @(negedge clk);
        chk("stall_in_reset", 72'(stall_w), 72'(0));
        #1 v = '0; opv = '0;
        @(posedge clk); #1 rst = 2'b11;

        repeat (4) begin
            @(negedge clk);
            chk("idle_outputs", 72'({hi_w[0], lo_w[0], stall_w[0], ms_w[0], ds_w[0]}), 72'(0));
        end

        // MULTU, zero-latency multiplier
        mr[0] = 1'b1; mz[0] = 64'hFFFFFFFE_00000001;
        push(0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run(0, 3'd2, 32'h0, 5, 1, st, ms, ds, ec, msg, dsg);
        chk("multu_stall", 72'(st), 72'(2));
        chk("multu_start", 72'(ms), 72'(1));
        chk("multu_signed", 72'(msg), 72'(0));

        // MULT, ready in third wait cycle
        mz[0] = 64'h00000001_80000000;
        push(0, 32'h00000001, 32'h80000000, 1'b0);
        run(0, 3'd1, 32'h0, 8, 3, st, ms, ds, ec, msg, dsg);
        chk("mult_stall", 72'(st), 72'(4));
        chk("mult_start", 72'(ms), 72'(3));
        chk("mult_signed", 72'(msg), 72'(1));

        // DIVU, ready after 33 wait cycles
        dq[0] = 32'd14; drem[0] = 32'd2;
        push(0, 32'h00000002, 32'h0000000E, 1'b0);
        run(0, 3'd4, 32'h0, 40, 33, st, ms, ds, ec, msg, dsg);
        chk("divu_stall", 72'(st), 72'(34));
        chk("divu_start", 72'(ds), 72'(33));
        chk("divu_signed", 72'(dsg), 72'(0));
        chk("divu_err", 72'(ec), 72'(0));

        // DIV by zero: whatever the divider presents is captured
        dq[0] = 32'hFFFFFFFF; drem[0] = 32'h0;
        push(0, 32'h0, 32'hFFFFFFFF, 1'b0);
        run(0, 3'd3, 32'h0, 4, 1, st, ms, ds, ec, msg, dsg);
        chk("div_stall", 72'(st), 72'(2));
        chk("div_signed", 72'(dsg), 72'(1));

        // reserved op: no stall, no update
        run(0, 3'd7, 32'h55, 3, 0, st, ms, ds, ec, msg, dsg);
        chk("op7_stall", 72'(st), 72'(0));
        chk("op7_hilo", 72'({hi_w[0], lo_w[0]}), 72'({32'h0, 32'hFFFFFFFF}));

        // MTHI then MTLO back to back
        push(0, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
        push(0, 32'hDEADBEEF, 32'h12345678, 1'b0);
        @(posedge clk); #1 v[0] = 1'b1; opv[0] = 3'd5; rsd[0] = 32'hDEADBEEF;
        @(negedge clk); chk("mthi_stall", 72'(stall_w[0]), 72'(0));
        @(posedge clk); #1 opv[0] = 3'd6; rsd[0] = 32'h12345678;
        @(negedge clk);
        chk("mtlo_stall", 72'(stall_w[0]), 72'(0));
        chk("mthi_hilo", 72'({hi_w[0], lo_w[0]}), 72'({32'hDEADBEEF, 32'hFFFFFFFF}));
        @(posedge clk); #1 v[0] = 1'b0; opv[0] = 3'd0;
        @(negedge clk);
        chk("mtlo_hilo", 72'({hi_w[0], lo_w[0]}), 72'({32'hDEADBEEF, 32'h12345678}));

        // Timeout on the 8-cycle instance, HI/LO preloaded
        push(1, 32'hA, 32'h0, 1'b0);
        push(1, 32'hA, 32'hB, 1'b0);
        @(posedge clk); #1 v[1] = 1'b1; opv[1] = 3'd5; rsd[1] = 32'hA;
        @(posedge clk); #1 opv[1] = 3'd6; rsd[1] = 32'hB;
        @(posedge clk); #1 v[1] = 1'b0; opv[1] = 3'd0;
        push(1, 32'hA, 32'hB, 1'b1);
        run(1, 3'd3, 32'h0, 14, 0, st, ms, ds, ec, msg, dsg);
        chk("tmo_stall", 72'(st), 72'(9));
        chk("tmo_start", 72'(ds), 72'(8));
        chk("tmo_err", 72'(ec), 72'(1));

        // ready in final allowed cycle beats timeout
        dq[1] = 32'd5; drem[1] = 32'd6;
        push(1, 32'd6, 32'd5, 1'b0);
        run(1, 3'd4, 32'h0, 14, 8, st, ms, ds, ec, msg, dsg);
        chk("last_stall", 72'(st), 72'(9));
        chk("last_err", 72'(ec), 72'(0));

        // reset in the middle of a MULT wait
        mr[0] = 1'b0; mz[0] = 64'h11112222_33334444;
        run(0, 3'd1, 32'h0, 3, 0, st, ms, ds, ec, msg, dsg);
        chk("pre_reset_start", 72'(ms), 72'(3));
        @(posedge clk); #3 rst[0] = 1'b0;
        #1 chk("reset_outputs", 72'({hi_w[0], lo_w[0], stall_w[0], ms_w[0], ds_w[0], msg_w[0], dsg_w[0], err_w[0]}), 72'(0));
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b1; mr[0] = 1'b1;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            acc += int'(stall_w[0]) + int'(ms_w[0]);
        end
        chk("post_reset_idle", 72'(acc), 72'(0));
        chk("post_reset_hilo", 72'({hi_w[0], lo_w[0]}), 72'(0));
        mr[0] = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_a_drained", 72'(q0.size()), 72'(0));
        chk("queue_b_drained", 72'(q1.size()), 72'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
